// File: rtl/serial_fullsub.sv
// Bit-serial full subtractor: one difference bit per clock, LSB first, start/busy/done handshake.
// Optional SERIAL_FULLSUB_ADD_MODE_EN adds a mode input selecting full-adder operation.
module serial_fullsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef SERIAL_FULLSUB_ADD_MODE_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             add_q;
    logic             d;
    logic             brw_next;

    // Single cell: subtract by default, add when the latched mode selects it.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        d        = opa[0] ^ opb[0] ^ brw;
        brw_next = (~opa[0] & opb[0]) | (~(opa[0] ^ opb[0]) & brw);
        if (add_q) begin
            brw_next = (opa[0] & opb[0]) | ((opa[0] ^ opb[0]) & brw);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            sr    <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            add_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        brw   <= bin;
`ifdef SERIAL_FULLSUB_ADD_MODE_EN
                        add_q <= mode;
`else
                        add_q <= 1'b0;
`endif
                        sr    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= {d, sr[WIDTH-1:1]};
                    opa <= opa >> 1;
                    opb <= opb >> 1;
                    brw <= brw_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // diff is written only here, never with partial bits.
                        diff  <= {d, sr[WIDTH-1:1]};
                        bout  <= brw_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_fullsub.sv
// Directed scoreboard bench for serial_fullsub; expected results are queued at issue
// and compared when done pulses. Define SERIAL_FULLSUB_ADD_MODE_EN to cover add mode.
module tb_serial_fullsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         mode;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int vectors = 0;
    int errors  = 0;

    logic [W:0]   sb[$];
    logic [W-1:0] last_diff;
    logic         last_bout;

    serial_fullsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
`ifdef SERIAL_FULLSUB_ADD_MODE_EN
        .mode  (mode),
`endif
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation; optionally inject a start with new operands before SHIFT edge 'inject'.
    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                      input logic modev, input int inject);
        logic [W:0] r;
        logic [W:0] e;
        if (modev) r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, binv};
        else       r = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv};
        sb.push_back(r);
        @(negedge clk);
        a = av; b = bv; bin = binv; mode = modev; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~av; b = ~bv; bin = ~binv; mode = ~modev;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        for (int i = 1; i <= W; i++) begin
            if (i == inject) begin
                @(negedge clk);
                start = 1'b1; a = 8'h00; b = 8'hFF; bin = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (i < W) begin
                check("done_early", done, 0);
                check("busy_shift", busy, 1);
                check("diff_held_shift", diff, last_diff);
            end
        end
        check("done_pulse", done, 1);
        e = sb.pop_front();
        check("diff", diff, e[W-1:0]);
        check("bout", bout, e[W]);
        last_diff = e[W-1:0];
        last_bout = e[W];
        @(posedge clk); #1;
        check("done_drop", done, 0);
        check("busy_drop", busy, 0);
        @(posedge clk); #1;
        check("no_second_done", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0; mode = 1'b0;
        last_diff = '0; last_bout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        rst = 1'b0;

        op(8'h5A, 8'h1F, 1'b0, 1'b0, 0);
        op(8'h00, 8'h01, 1'b0, 1'b0, 0);
        op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        op(8'h10, 8'h0F, 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_hold_diff", diff, 8'h00);
            check("idle_hold_done", done, 0);
        end

        // Start ignored while busy.
        op(8'h80, 8'h01, 1'b0, 1'b0, 3);

        // Reset at the 4th SHIFT edge aborts the operation.
        @(negedge clk);
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        last_diff = '0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 0);
        end
        op(8'h03, 8'h02, 1'b0, 1'b0, 0);

`ifdef SERIAL_FULLSUB_ADD_MODE_EN
        op(8'hF0, 8'h20, 1'b0, 1'b1, 0);
        op(8'hF0, 8'h20, 1'b0, 1'b0, 0);
        op(8'hFF, 8'h01, 1'b1, 1'b1, 0);
`endif
        op(8'hA5, 8'h5A, 1'b1, 1'b0, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
